// File: rtl/fetch_unit.sv
// Purpose : instruction fetch front end; one outstanding imem request, single output slot to the datapath.
// Latency : instruction is presented on Instr/PC one cycle after the imem_rvalid edge.
// Backpress: stall holds the output slot; no new request is issued while the slot is full and stalled.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_gnt      - request handshake to instruction memory
//   imem_rvalid/imem_rdata           - response (1+ cycles after grant, at most one per grant)
//   redirect/redirect_pc             - taken branch/jump, replaces the fetch stream
//   stall                            - datapath cannot accept an instruction this cycle
//   instr_valid/Instr/PC/PCPlus4     - output slot to the datapath
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4
);

   // Low address bits are forced to zero so every fetch is word aligned.
   localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        kill_q, kill_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;

   logic        slot_ok;
   logic        grant;
   logic [31:0] redirect_tgt;

   // A request may only go out when the slot is empty or is being consumed
   // this edge, so a returning response always has somewhere to land.
   assign slot_ok      = !instr_valid_q || !stall;
   assign imem_req     = (state_q == S_REQ) && slot_ok;
   assign imem_addr    = fetch_pc_q;
   assign grant        = imem_req && imem_gnt;
   assign redirect_tgt = redirect_pc & ~32'h3;

   assign instr_valid  = instr_valid_q;
   assign Instr        = instr_q;
   assign PC           = pc_q;
   assign PCPlus4      = pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      kill_d        = kill_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      // Consumption: an unstalled valid instruction leaves the slot this edge.
      instr_valid_d = instr_valid_q && stall;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect) begin
               fetch_pc_d    = redirect_tgt;
               instr_valid_d = 1'b0;
            end
         end

         S_REQ: begin
            if (redirect) begin
               fetch_pc_d    = redirect_tgt;
               instr_valid_d = 1'b0;
               // A request granted this same cycle is already in flight for
               // the old stream; its response must be thrown away.
               if (grant) begin
                  kill_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else if (grant) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect) begin
               fetch_pc_d    = redirect_tgt;
               instr_valid_d = 1'b0;
               if (imem_rvalid) begin
                  // Response arriving with the redirect is dropped here, so
                  // nothing remains in flight to be killed later.
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (imem_rvalid) begin
               state_d = S_REQ;
               if (kill_q) begin
                  kill_d = 1'b0;
               end else begin
                  instr_d       = imem_rdata;
                  pc_d          = fetch_pc_q;
                  instr_valid_d = 1'b1;
                  fetch_pc_d    = fetch_pc_q + 32'd4;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= BOOT_PC;
         kill_q        <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= NOP;
         pc_q          <= BOOT_PC;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         kill_q        <= kill_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed self-checking bench for fetch_unit with a delivery scoreboard.
// Latency : inputs change 1 time unit after posedge; all sampling happens on negedge.
// Backpress: stall is driven by the directed sequence; the monitor only checks consumed instructions.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr_valid (instr_valid),
      .Instr       (Instr),
      .PC          (PC),
      .PCPlus4     (PCPlus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      sb_q.push_back(e);
   endtask

   // Monitor: every instruction the datapath actually consumes is checked
   // against the oldest expected delivery.
   always @(negedge clk) begin
      if (reset && instr_valid && !stall) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_unexpected: got Instr=0x%08h PC=0x%08h, none expected", Instr, PC);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_instr", Instr, e.instr);
            chk("sb_pc", PC, e.pc);
            chk("sb_pcplus4", PCPlus4, e.pc + 32'd4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;

      // ---- reset values
      step(); step();
      at_neg();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", Instr, 32'h0000_0013);
      chk("rst_pc", PC, 32'h0);
      chk("rst_pcplus4", PCPlus4, 32'h4);

      // ---- release: IDLE one cycle, request in the second cycle
      step();
      reset = 1'b1;
      at_neg();
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      at_neg();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // ---- zero-wait fetch from 0x0
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      push_exp(32'h0050_0093, 32'h0);
      at_neg();
      chk("wait_req_low", {31'd0, imem_req}, 32'd0);
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("zw_valid", {31'd0, instr_valid}, 32'd1);
      chk("zw_next_req", {31'd0, imem_req}, 32'd1);
      chk("zw_next_addr", imem_addr, 32'h4);

      // ---- stall holds the slot and suppresses requests
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1111_1111;
      stall       = 1'b1;
      push_exp(32'h1111_1111, 32'h4);
      step();
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b1;   // grant without request must be ignored
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_instr", Instr, 32'h1111_1111);
         chk("stall_pc", PC, 32'h4);
         step();
      end
      stall = 1'b0;
      at_neg();
      chk("unstall_req", {31'd0, imem_req}, 32'd1);
      chk("unstall_addr", imem_addr, 32'h8);
      step();
      imem_gnt = 1'b0;
      at_neg();
      chk("single_req", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2222_2222;
      push_exp(32'h2222_2222, 32'h8);
      step();
      imem_rvalid = 1'b0;

      // ---- redirect while waiting; late response dropped
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      at_neg();
      chk("kill_wait_req", {31'd0, imem_req}, 32'd0);
      chk("kill_wait_valid", {31'd0, instr_valid}, 32'd0);
      step(); step();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("kill_valid", {31'd0, instr_valid}, 32'd0);
      chk("kill_req", {31'd0, imem_req}, 32'd1);
      chk("kill_addr", imem_addr, 32'h100);
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h3333_3333;
      push_exp(32'h3333_3333, 32'h100);
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("post_kill_addr", imem_addr, 32'h104);

      // ---- unaligned redirect in REQ without grant
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      at_neg();
      chk("align_req", {31'd0, imem_req}, 32'd1);
      chk("align_addr", imem_addr, 32'h200);

      // ---- redirect with same-cycle grant, then wrap at top of memory
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      imem_gnt    = 1'b1;
      step();
      redirect    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0BAD;
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("gntredir_valid", {31'd0, instr_valid}, 32'd0);
      chk("gntredir_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h4444_4444;
      push_exp(32'h4444_4444, 32'hFFFF_FFFC);
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("wrap_pcplus4", PCPlus4, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);

      // ---- redirect and rvalid in the same WAIT cycle
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h5555_5555;
      step();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      at_neg();
      chk("redir_rv_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_rv_req", {31'd0, imem_req}, 32'd1);
      chk("redir_rv_addr", imem_addr, 32'h40);
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h6666_6666;
      push_exp(32'h6666_6666, 32'h40);
      step();
      imem_rvalid = 1'b0;

      // ---- grant withheld 4 cycles; stray rvalid outside WAIT ignored
      for (int i = 0; i < 4; i++) begin
         imem_rvalid = (i == 1);
         imem_rdata  = 32'hBADB_AD00;
         at_neg();
         chk("hold_req", {31'd0, imem_req}, 32'd1);
         chk("hold_addr", imem_addr, 32'h44);
         step();
      end
      imem_rvalid = 1'b0;
      at_neg();
      chk("stray_rv_valid", {31'd0, instr_valid}, 32'd0);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;

      // ---- asynchronous reset mid-WAIT, between clock edges
      #2;
      reset = 1'b0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_instr", Instr, 32'h0000_0013);
      chk("arst_pc", PC, 32'h0);
      step(); step();
      reset       = 1'b1;
      imem_rvalid = 1'b1;   // late response from the abandoned request
      imem_rdata  = 32'hBADB_AD01;
      step();
      imem_rvalid = 1'b0;
      at_neg();
      chk("late_rv_valid", {31'd0, instr_valid}, 32'd0);
      chk("late_rv_req", {31'd0, imem_req}, 32'd1);
      chk("late_rv_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h7777_7777;
      push_exp(32'h7777_7777, 32'h0);
      step();
      imem_rvalid = 1'b0;
      step(); step();
      at_neg();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset: 0 clears all state immediately, independent of clk.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  fetch address, word aligned.
REQ-006 imem_gnt  in  1  request accepted this cycle (handshake with imem_req).
REQ-007 imem_rvalid  in  1  read data valid; at most one response per grant, arriving 1 or more cycles after grant.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 redirect  in  1  branch/jump taken; replaces fetch stream.
REQ-010 redirect_pc  in  32  redirect target (PCTarget).
REQ-011 stall  in  1  datapath cannot accept an instruction this cycle.
REQ-012 instr_valid  out  1  Instr/PC hold a valid instruction.
REQ-013 Instr  out  32  instruction to datapath.
REQ-014 PC  out  32  address of Instr.
REQ-015 PCPlus4  out  32  PC + 4, combinational, modulo 2^32.

Function
REQ-016 States: IDLE, REQ, WAIT; internal regs fetch_pc[31:0], kill[0].
REQ-017 IDLE: imem_req=0; entered only by reset; next cycle -> REQ.
REQ-018 REQ: imem_addr=fetch_pc; imem_req=1 only when output slot free or freeing (instr_valid==0 or stall==0), else 0.
REQ-019 REQ with imem_req=1 and imem_gnt=1 -> WAIT; without gnt, imem_req and imem_addr held stable until gnt, except on redirect.
REQ-020 Maximum one outstanding request; imem_req=0 in WAIT and IDLE.
REQ-021 WAIT with imem_rvalid=1, kill=0, redirect=0: Instr<=imem_rdata, PC<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4, -> REQ.
REQ-022 WAIT with imem_rvalid=1 and kill=1: data discarded, kill<=0, outputs unchanged, -> REQ.
REQ-023 Consumption: instr_valid && !stall consumes the instruction; instr_valid<=0 that edge unless loaded per REQ-021 same edge.
REQ-024 While stall=1, instr_valid, Instr, PC SHALL hold.
REQ-025 Redirect has highest priority: fetch_pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, Instr/PC unchanged.
REQ-026 Redirect in WAIT, or in REQ with gnt same cycle: kill<=1, state WAIT; in-flight response later discarded.
REQ-027 Redirect in REQ without gnt: stay REQ; imem_addr shows new fetch_pc from next cycle.
REQ-028 Redirect and rvalid same cycle in WAIT: response discarded, kill stays 0, -> REQ.
REQ-029 imem_rvalid outside WAIT and imem_gnt while imem_req=0 SHALL be ignored.
REQ-030 fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000; PCPlus4 wraps likewise.
REQ-031 Fetched instruction to datapath latency: 1 cycle after the rvalid edge.

Reset
REQ-032 reset=0 forces: state IDLE, fetch_pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=32'h0000_0013 (NOP), PC=RESET_PC.
REQ-033 Reset mid-WAIT abandons the request; a late rvalid after release SHALL be ignored per REQ-029.
REQ-034 First imem_req=1 occurs in the second cycle after reset release.

Verification
REQ-035 Zero-wait memory (gnt=1, rvalid next cycle), rdata=0x00500093 at 0x0, stall=0 -> Instr=0x00500093, PC=0, PCPlus4=4, instr_valid=1; next request addr=4.
REQ-036 stall=1 for 5 cycles while instr_valid=1 -> Instr/PC held, imem_req=0 throughout; one request issued on stall release.
REQ-037 redirect=1, redirect_pc=0x100 in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> data dropped, instr_valid=0, next imem_addr=0x100.
REQ-038 redirect_pc=0x203 -> fetch from 0x200; fetch_pc=0xFFFFFFFC fetched -> next imem_addr=0x0, PCPlus4=0x0.
REQ-039 gnt withheld 4 cycles -> imem_req=1, imem_addr stable all 4 cycles; reset=0 asserted mid-WAIT (no clk edge) -> outputs at REQ-032 values immediately.
